// File: rtl/vga_draw_scheduler.sv
// Sequences up to three VGA draw units (clear, tile, sprite) once per frame, handing
// the shared bus grant directly from one enabled unit to the next with a per-unit watchdog.
module vga_draw_scheduler #(
  parameter logic [16:0] TIMEOUT_CYCLES = 17'd70000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] unit_mask,
  input  logic [2:0] unit_done,
  input  logic       err_clr,
  output logic [2:0] unit_start,
  output logic [2:0] unit_grant,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       timeout_err,
  output logic [1:0] timeout_unit,
  output logic [1:0] state_dbg
);

  // Handshake: unit_start is a one-cycle pulse; the granted unit answers with a one-cycle
  // unit_done pulse on its own bit, accepted only while the scheduler waits on that unit.
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, FDONE = 2'd3} state_t;

  state_t      state, state_n;
  logic [2:0]  mask_q, mask_n;
  logic [1:0]  idx, idx_n;
  logic [16:0] timer, timer_n;
  logic [2:0]  first_new, first_next;
  logic        done_hit, tmo_hit;
  logic [2:0]  idx_onehot;

  // Returns {found, index} of the lowest set bit of m at position lo or above.
  function automatic logic [2:0] first_from(input logic [2:0] m, input int lo);
    logic       found;
    logic [1:0] n;
    found = 1'b0;
    n     = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (m[k] && k >= lo) begin
        found = 1'b1;
        n     = 2'(k);
      end
    end
    return {found, n};
  endfunction

  assign first_new  = first_from(unit_mask, 0);
  assign first_next = first_from(mask_q, int'(idx) + 1);
  assign done_hit   = (state == WAIT) && unit_done[idx];
  // A done pulse on the final allowed cycle wins over the watchdog.
  assign tmo_hit    = (state == WAIT) && (timer == TIMEOUT_CYCLES - 17'd1) && !unit_done[idx];

  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    idx_n   = idx;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          mask_n = unit_mask;
          if (first_new[2]) begin
            state_n = START;
            idx_n   = first_new[1:0];
          end else begin
            state_n = FDONE;
          end
        end
      end
      START: begin
        timer_n = 17'd0;
        state_n = WAIT;
      end
      WAIT: begin
        timer_n = timer + 17'd1;
        if (done_hit || tmo_hit) begin
          if (first_next[2]) begin
            state_n = START;
            idx_n   = first_next[1:0];
          end else begin
            state_n = FDONE;
          end
        end
      end
      FDONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mask_q       <= 3'd0;
      idx          <= 2'd0;
      timer        <= 17'd0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      timeout_unit <= 2'd0;
    end else begin
      state       <= state_n;
      mask_q      <= mask_n;
      idx         <= idx_n;
      timer       <= timer_n;
      overrun     <= (frame_tick && state != IDLE) || (overrun && !err_clr);
      timeout_err <= tmo_hit || (timeout_err && !err_clr);
      if (tmo_hit) timeout_unit <= idx;
    end
  end

  assign idx_onehot = 3'b001 << idx;
  assign unit_start = (state == START) ? idx_onehot : 3'b000;
  assign unit_grant = (state == START || state == WAIT) ? idx_onehot : 3'b000;
  assign busy       = (state != IDLE);
  assign frame_done = (state == FDONE);
  assign state_dbg  = state;

endmodule

// File: doc/vga_draw_scheduler.md
VGA_DRAW_SCHEDULER -- requirements
Module: vga_draw_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 17'd70000, max cycles a unit may hold the bus before it is forcibly advanced.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse requesting a new frame draw sequence.
REQ-005 unit_mask  input  3  per-unit enable (bit0 screen clear, bit1 tile drawer, bit2 sprite drawer); sampled only at frame start.
REQ-006 unit_done  input  3  one-cycle done pulses from the three draw units, bit-aligned with unit_mask.
REQ-007 err_clr  input  1  clears the sticky error flags.
REQ-008 unit_start  output  3  one-hot, one-cycle enable pulse to the selected draw unit.
REQ-009 unit_grant  output  3  one-hot level, the unit allowed to drive the shared tri-state VGA bus.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse at the end of a sequence.
REQ-012 overrun  output  1  sticky: frame_tick arrived while busy.
REQ-013 timeout_err  output  1  sticky: a unit exceeded TIMEOUT_CYCLES.
REQ-014 timeout_unit  output  2  index (0-2) of the most recent timed-out unit.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT, FDONE; all outputs except the sticky flags are decoded from registered state only (Moore).
REQ-016 IDLE: on frame_tick=1, latch mask_q<=unit_mask; if unit_mask==0, next state is FDONE; otherwise next state is START with idx = lowest set bit.
REQ-017 START: unit_start[idx]=1 and unit_grant[idx]=1 for exactly this cycle; clear timer to 0; next state is WAIT.
REQ-018 WAIT: unit_grant[idx]=1, unit_start=0; timer increments by 1 each cycle (17-bit, no wrap, since timeout fires first).
REQ-019 WAIT: if unit_done[idx]=1, advance: next state is START with idx = lowest set bit of mask_q above idx, or FDONE if none.
REQ-020 WAIT: if timer==TIMEOUT_CYCLES-1 and unit_done[idx]=0, set timeout_err, set timeout_unit<=idx, and advance as in REQ-019.
REQ-021 unit_done bits other than idx, and any unit_done outside WAIT, SHALL be ignored.
REQ-022 Done and timeout in the same cycle SHALL count as done (no error).
REQ-023 FDONE: frame_done=1, unit_grant=0 for one cycle; next state is IDLE.
REQ-024 Grant handover between units SHALL be direct (START of next unit follows the final WAIT cycle), with no idle gap and never two grant bits set.
REQ-025 frame_tick when state != IDLE SHALL be dropped (no queuing) and SHALL set overrun.
REQ-026 Changes to unit_mask mid-sequence SHALL have no effect until the next frame start.
REQ-027 err_clr SHALL clear overrun and timeout_err next cycle; a set event in the same cycle wins over the clear.
REQ-028 Latency: frame_tick at cycle N gives unit_start at N+1; unit_done at cycle M gives the next unit_start, or frame_done, at M+1.

Reset
REQ-029 reset SHALL force state=IDLE, mask_q=0, idx=0, timer=0, unit_start=0, unit_grant=0, busy=0, frame_done=0, overrun=0, timeout_err=0, timeout_unit=0 on the next posedge.
REQ-030 reset mid-sequence SHALL drop grant immediately after that edge, with no frame_done pulse; reset overrides frame_tick and err_clr in the same cycle.

Verification
REQ-031 mask=3'b111, frame_tick, each unit done 10 cycles after its start -> starts 001,010,100 in order, frame_done once, busy for 3x(1+10)+1 cycles, no errors.
REQ-032 mask=3'b101 -> unit 1 never started or granted; sequence is unit0 then unit2; mask=3'b000 -> frame_done on the cycle after frame_tick.
REQ-033 TIMEOUT_CYCLES=20, unit1 never done -> after 20 WAIT cycles timeout_err=1, timeout_unit=1, unit2 started next cycle; err_clr -> timeout_err=0.
REQ-034 frame_tick during WAIT -> overrun=1, sequence unaffected, no second sequence; a stray unit_done[2] while unit0 is granted is ignored.
REQ-035 reset asserted during WAIT of unit1 -> next cycle all outputs 0 and state IDLE; a following frame_tick starts a normal sequence.
